// File: rtl/mmio_bridge.sv
// Memory-mapped I/O router: data RAM, RNG, dot-location display FIFO, status and generation counter.
// Optional build macro MMIO_SEG_LOAD_EN: stores to SEG_ADDR with wdata MSB set load the counter directly.
module mmio_bridge #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int RAM_AW      = 12,
  parameter int RNG_ADDR    = 99,
  parameter int DOT_BASE    = 100,
  parameter int DOT_COUNT   = 450,
  parameter int SEG_ADDR    = 1000,
  parameter int STATUS_ADDR = 1001,
  parameter int FIFO_DEPTH  = 8,
  parameter int CNT_W       = 14,
  localparam int DOT_IDW    = (DOT_COUNT > 1) ? $clog2(DOT_COUNT) : 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  cpu_addr,
  input  logic [DATA_W-1:0]  cpu_wdata,
  input  logic               cpu_wren,
  output logic [DATA_W-1:0]  cpu_rdata,
  output logic [RAM_AW-1:0]  ram_addr,
  output logic               ram_wren,
  output logic [DATA_W-1:0]  ram_wdata,
  input  logic [DATA_W-1:0]  ram_rdata,
  input  logic [DATA_W-1:0]  rng_data,
  output logic               dot_valid,
  input  logic               dot_ready,
  output logic               dot_is_y,
  output logic [DOT_IDW-1:0] dot_id,
  output logic [DATA_W-1:0]  dot_loc,
  output logic [CNT_W-1:0]   seg_value,
  output logic               dot_overflow
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int ENTRY_W = 1 + DOT_IDW + DATA_W;

  localparam logic [ADDR_W-1:0] RNG_A   = ADDR_W'(RNG_ADDR);
  localparam logic [ADDR_W-1:0] SEG_A   = ADDR_W'(SEG_ADDR);
  localparam logic [ADDR_W-1:0] STAT_A  = ADDR_W'(STATUS_ADDR);
  localparam logic [ADDR_W-1:0] X_LO    = ADDR_W'(DOT_BASE);
  localparam logic [ADDR_W-1:0] Y_LO    = ADDR_W'(DOT_BASE + DOT_COUNT);
  localparam logic [ADDR_W-1:0] Y_END   = ADDR_W'(DOT_BASE + 2 * DOT_COUNT);
  localparam logic [ADDR_W-1:0] RAM_END = ADDR_W'(64'd1 << RAM_AW);
  localparam logic [PTR_W:0]    FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    REG_NONE,
    REG_RAM,
    REG_RNG,
    REG_SEG,
    REG_STAT,
    REG_DOT_X,
    REG_DOT_Y
  } region_t;

  region_t region;
  region_t region_q;

  // Priority decode: single addresses first, then the dot windows, then RAM.
  always_comb begin
    region = REG_NONE;
    if (cpu_addr == RNG_A)                             region = REG_RNG;
    else if (cpu_addr == SEG_A)                        region = REG_SEG;
    else if (cpu_addr == STAT_A)                       region = REG_STAT;
    else if (cpu_addr >= X_LO && cpu_addr < Y_LO)      region = REG_DOT_X;
    else if (cpu_addr >= Y_LO && cpu_addr < Y_END)     region = REG_DOT_Y;
    else if (cpu_addr < RAM_END)                       region = REG_RAM;
  end

  assign ram_addr  = cpu_addr[RAM_AW-1:0];
  assign ram_wdata = cpu_wdata;
  assign ram_wren  = cpu_wren && (region == REG_RAM);

  // ---------------------------------------------------------------------------
  // Dot FIFO. Handshake: the head entry is offered while dot_valid=1 and is
  // consumed on the rising clock edge where dot_valid && dot_ready; the
  // display may raise dot_ready at any time, dot_valid never depends on it.
  // ---------------------------------------------------------------------------
  logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W:0]     fifo_count;
  logic               fifo_full;
  logic               is_dot;
  logic               push_req;
  logic               push;
  logic               pop;
  logic               drop;
  logic [DOT_IDW-1:0] push_id;
  logic [ENTRY_W-1:0] push_entry;
  logic [ENTRY_W-1:0] head;

  assign is_dot     = (region == REG_DOT_X) || (region == REG_DOT_Y);
  assign push_id    = (region == REG_DOT_Y) ? DOT_IDW'(cpu_addr - Y_LO)
                                            : DOT_IDW'(cpu_addr - X_LO);
  assign push_entry = {region == REG_DOT_Y, push_id, cpu_wdata};

  assign fifo_full  = (fifo_count == FULL_COUNT);
  assign dot_valid  = (fifo_count != '0);
  assign pop        = dot_valid && dot_ready;
  assign push_req   = cpu_wren && is_dot;
  // A pop in the same edge frees the slot, so a full FIFO still accepts.
  assign push       = push_req && (!fifo_full || pop);
  assign drop       = push_req && fifo_full && !pop;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr] <= push_entry;
  end

  // Head fields are forced to zero when empty so stale storage never leaks out.
  assign head     = fifo_mem[rd_ptr];
  assign dot_is_y = dot_valid && head[ENTRY_W-1];
  assign dot_id   = dot_valid ? head[ENTRY_W-2 -: DOT_IDW] : '0;
  assign dot_loc  = dot_valid ? head[DATA_W-1:0] : '0;

  // ---------------------------------------------------------------------------
  // Sticky overflow flag; a drop on the same edge as a clear keeps it set.
  // ---------------------------------------------------------------------------
  logic stat_store;
  assign stat_store = cpu_wren && (region == REG_STAT);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dot_overflow <= 1'b0;
    end else if (drop) begin
      dot_overflow <= 1'b1;
    end else if (stat_store && cpu_wdata[0]) begin
      dot_overflow <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Generation counter
  // ---------------------------------------------------------------------------
  logic seg_store;
  assign seg_store = cpu_wren && (region == REG_SEG);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      seg_value <= '0;
    end else if (seg_store) begin
`ifdef MMIO_SEG_LOAD_EN
      if (cpu_wdata[DATA_W-1]) seg_value <= cpu_wdata[CNT_W-1:0];
      else                     seg_value <= seg_value + 1'b1;
`else
      seg_value <= seg_value + 1'b1;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Read path: capture selection and volatile sources at N, mux at N+1.
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] rng_q;
  logic [DATA_W-1:0] status_q;
  logic [DATA_W-1:0] status_word;

  assign status_word = DATA_W'({fifo_count, dot_overflow});

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      region_q <= REG_NONE;
      rng_q    <= '0;
      status_q <= '0;
    end else begin
      region_q <= region;
      rng_q    <= rng_data;
      status_q <= status_word;
    end
  end

  always_comb begin
    cpu_rdata = '0;
    case (region_q)
      REG_RAM:  cpu_rdata = ram_rdata;
      REG_RNG:  cpu_rdata = rng_q;
      REG_STAT: cpu_rdata = status_q;
      REG_SEG:  cpu_rdata = DATA_W'(seg_value);
      default:  cpu_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_mmio_bridge.sv
// Directed bench for mmio_bridge: RAM/RNG reads, dot FIFO order and overflow, counter, async reset.
module tb_mmio_bridge;

  logic        clock;
  logic        reset;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_wren;
  logic [31:0] cpu_rdata;
  logic [11:0] ram_addr;
  logic        ram_wren;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic [31:0] rng_data;
  logic        dot_valid;
  logic        dot_ready;
  logic        dot_is_y;
  logic [8:0]  dot_id;
  logic [31:0] dot_loc;
  logic [13:0] seg_value;
  logic        dot_overflow;

  int tests_run;
  int tests_failed;

  mmio_bridge dut (
    .clock        (clock),
    .reset        (reset),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_wren     (cpu_wren),
    .cpu_rdata    (cpu_rdata),
    .ram_addr     (ram_addr),
    .ram_wren     (ram_wren),
    .ram_wdata    (ram_wdata),
    .ram_rdata    (ram_rdata),
    .rng_data     (rng_data),
    .dot_valid    (dot_valid),
    .dot_ready    (dot_ready),
    .dot_is_y     (dot_is_y),
    .dot_id       (dot_id),
    .dot_loc      (dot_loc),
    .seg_value    (seg_value),
    .dot_overflow (dot_overflow)
  );

  // clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // synchronous 1-cycle RAM
  logic [31:0] ram_mem [4096];
  always @(posedge clock) begin
    if (ram_wren) ram_mem[ram_addr] <= ram_wdata;
    ram_rdata <= ram_mem[ram_addr];
  end

  // driver tasks
  task automatic do_store(input logic [31:0] a, input logic [31:0] d);
    @(negedge clock);
    cpu_addr  = a;
    cpu_wdata = d;
    cpu_wren  = 1'b1;
    @(posedge clock);
    #1;
    cpu_wren  = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] a, output logic [31:0] d);
    @(negedge clock);
    cpu_addr = a;
    cpu_wren = 1'b0;
    @(posedge clock);
    @(negedge clock);
    d = cpu_rdata;
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    cpu_wren  = 1'b0;
    dot_ready = 1'b0;
    rng_data  = '0;
    repeat (3) @(posedge clock);
    #1;
    tests_run++;
    if ({dot_valid, dot_is_y, dot_id, dot_loc, seg_value, dot_overflow, cpu_rdata} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: valid=%b y=%b id=%0d loc=%h seg=%0d ovf=%b rdata=%h, required all 0",
               dot_valid, dot_is_y, dot_id, dot_loc, seg_value, dot_overflow, cpu_rdata);
    end
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_ram();
    logic [31:0] d;
    @(negedge clock);
    cpu_addr = 32'd5; cpu_wdata = 32'h1234; cpu_wren = 1'b1;
    #1;
    tests_run++;
    if (ram_wren !== 1'b1) begin
      tests_failed++; $display("FAIL ram_wren_store: got %b required 1", ram_wren);
    end
    @(posedge clock); #1; cpu_wren = 1'b0;
    do_load(32'd5, d);
    tests_run++;
    if (d !== 32'h1234) begin
      tests_failed++; $display("FAIL ram_load: got %h required 00001234", d);
    end
    @(negedge clock);
    cpu_addr = 32'd100; cpu_wdata = 32'hAB; cpu_wren = 1'b1;
    #1;
    tests_run++;
    if (ram_wren !== 1'b0) begin
      tests_failed++; $display("FAIL ram_wren_mmio: got %b required 0", ram_wren);
    end
    @(posedge clock); #1; cpu_wren = 1'b0;
    tests_run++;
    if ({dot_valid, dot_is_y, dot_id, dot_loc} !== {1'b1, 1'b0, 9'd0, 32'hAB}) begin
      tests_failed++;
      $display("FAIL dot_x_base: got v=%b y=%b id=%0d loc=%h required v=1 y=0 id=0 loc=ab",
               dot_valid, dot_is_y, dot_id, dot_loc);
    end
    @(negedge clock); dot_ready = 1'b1;
    @(posedge clock); #1; dot_ready = 1'b0;
    do_load(32'd5000, d);
    tests_run++;
    if (d !== 32'h0) begin
      tests_failed++; $display("FAIL unmapped_load: got %h required 0", d);
    end
  endtask

  task automatic test_rng();
    @(negedge clock);
    cpu_addr = 32'd99; cpu_wren = 1'b0; rng_data = 32'hDEADBEEF;
    @(posedge clock); #1;
    rng_data = 32'h12345678; cpu_addr = 32'd0;
    @(negedge clock);
    tests_run++;
    if (cpu_rdata !== 32'hDEADBEEF) begin
      tests_failed++; $display("FAIL rng_sample: got %h required deadbeef", cpu_rdata);
    end
  endtask

  task automatic test_dot_fifo();
    dot_ready = 1'b0;
    do_store(32'd103, 32'd7);
    do_store(32'd551, 32'd9);
    @(negedge clock);
    tests_run++;
    if ({dot_valid, dot_is_y, dot_id, dot_loc} !== {1'b1, 1'b0, 9'd3, 32'd7}) begin
      tests_failed++;
      $display("FAIL fifo_head1: got v=%b y=%b id=%0d loc=%0d required v=1 y=0 id=3 loc=7",
               dot_valid, dot_is_y, dot_id, dot_loc);
    end
    dot_ready = 1'b1;
    @(posedge clock); #1;
    tests_run++;
    if ({dot_valid, dot_is_y, dot_id, dot_loc} !== {1'b1, 1'b1, 9'd1, 32'd9}) begin
      tests_failed++;
      $display("FAIL fifo_head2: got v=%b y=%b id=%0d loc=%0d required v=1 y=1 id=1 loc=9",
               dot_valid, dot_is_y, dot_id, dot_loc);
    end
    @(posedge clock); #1;
    tests_run++;
    if (dot_valid !== 1'b0) begin
      tests_failed++; $display("FAIL fifo_empty: got dot_valid=%b required 0", dot_valid);
    end
    @(posedge clock); #1;
    dot_ready = 1'b0;
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    dot_ready = 1'b0;
    for (int i = 0; i < 9; i++) do_store(32'd100 + 32'(i), 32'(i));
    tests_run++;
    if (dot_overflow !== 1'b1) begin
      tests_failed++; $display("FAIL overflow_set: got %b required 1", dot_overflow);
    end
    do_load(32'd1001, d);
    tests_run++;
    if (d !== 32'h11) begin
      tests_failed++; $display("FAIL status_full_ovf: got %h required 11", d);
    end
    do_store(32'd1001, 32'd1);
    tests_run++;
    if (dot_overflow !== 1'b0) begin
      tests_failed++; $display("FAIL overflow_clear: got %b required 0", dot_overflow);
    end
    dot_ready = 1'b1;
    for (int i = 0; i < 8; i++) do_store(32'd110 + 32'(i), 32'h100 + 32'(i));
    dot_ready = 1'b0;
    tests_run++;
    if (dot_overflow !== 1'b0) begin
      tests_failed++; $display("FAIL full_push_pop_ovf: got %b required 0", dot_overflow);
    end
    do_load(32'd1001, d);
    tests_run++;
    if (d !== 32'h10) begin
      tests_failed++; $display("FAIL status_full: got %h required 10", d);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      tests_run++;
      if ({dot_valid, dot_id, dot_loc} !== {1'b1, 9'(10 + i), 32'h100 + 32'(i)}) begin
        tests_failed++;
        $display("FAIL drain_order[%0d]: got v=%b id=%0d loc=%h required v=1 id=%0d loc=%h",
                 i, dot_valid, dot_id, dot_loc, 10 + i, 32'h100 + 32'(i));
      end
      dot_ready = 1'b1;
      @(posedge clock); #1;
      dot_ready = 1'b0;
    end
    tests_run++;
    if (dot_valid !== 1'b0) begin
      tests_failed++; $display("FAIL drain_empty: got dot_valid=%b required 0", dot_valid);
    end
  endtask

  task automatic test_counter();
    logic [31:0] d;
    for (int i = 0; i < 3; i++) do_store(32'd1000, 32'h0);
    tests_run++;
    if (seg_value !== 14'd3) begin
      tests_failed++; $display("FAIL seg_three: got %0d required 3", seg_value);
    end
    do_load(32'd1000, d);
    tests_run++;
    if (d !== 32'd3) begin
      tests_failed++; $display("FAIL seg_read: got %h required 3", d);
    end
    for (int i = 0; i < 16380; i++) do_store(32'd1000, 32'h0);
    tests_run++;
    if (seg_value !== 14'd16383) begin
      tests_failed++; $display("FAIL seg_max: got %0d required 16383", seg_value);
    end
    do_store(32'd1000, 32'h0);
    tests_run++;
    if (seg_value !== 14'd0) begin
      tests_failed++; $display("FAIL seg_wrap: got %0d required 0", seg_value);
    end
    do_store(32'd1000, 32'h8000_0064);
`ifdef MMIO_SEG_LOAD_EN
    tests_run++;
    if (seg_value !== 14'd100) begin
      tests_failed++; $display("FAIL seg_load: got %0d required 100", seg_value);
    end
`else
    tests_run++;
    if (seg_value !== 14'd1) begin
      tests_failed++; $display("FAIL seg_no_load: got %0d required 1", seg_value);
    end
`endif
  endtask

  task automatic test_async_reset();
    logic [31:0] d;
    dot_ready = 1'b0;
    for (int i = 0; i < 5; i++) do_store(32'd200 + 32'(i), 32'h40 + 32'(i));
    do_store(32'd1000, 32'h0);
    tests_run++;
    if ({dot_valid, dot_id} !== {1'b1, 9'd100}) begin
      tests_failed++; $display("FAIL pre_reset_head: got v=%b id=%0d required v=1 id=100", dot_valid, dot_id);
    end
    @(negedge clock);
    cpu_addr = 32'd100; cpu_wdata = 32'h77; cpu_wren = 1'b1; dot_ready = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    tests_run++;
    if ({dot_valid, dot_is_y, dot_id, dot_loc, seg_value, dot_overflow, cpu_rdata} !== '0) begin
      tests_failed++;
      $display("FAIL async_reset: valid=%b y=%b id=%0d loc=%h seg=%0d ovf=%b rdata=%h, required all 0",
               dot_valid, dot_is_y, dot_id, dot_loc, seg_value, dot_overflow, cpu_rdata);
    end
    cpu_wren = 1'b0;
    @(posedge clock); #1;
    tests_run++;
    if (dot_valid !== 1'b0) begin
      tests_failed++; $display("FAIL reset_hold: got dot_valid=%b required 0", dot_valid);
    end
    @(negedge clock);
    reset = 1'b1;
    dot_ready = 1'b0;
    do_store(32'd300, 32'h55);
    tests_run++;
    if ({dot_valid, dot_id, dot_loc} !== {1'b1, 9'd200, 32'h55}) begin
      tests_failed++;
      $display("FAIL post_reset_head: got v=%b id=%0d loc=%h required v=1 id=200 loc=55",
               dot_valid, dot_id, dot_loc);
    end
    do_load(32'd1001, d);
    tests_run++;
    if (d !== 32'h2) begin
      tests_failed++; $display("FAIL post_reset_status: got %h required 2", d);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_ram();
    test_rng();
    test_dot_fifo();
    test_overflow();
    test_counter();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mmio_bridge.md
Name: mmio_bridge

Overview:
- Parametrised memory-mapped I/O router between the processor data-memory port and the data RAM, RNG, dot-location display channel and 7-segment generation counter.
- Replaces the hard-coded address compares and the `posedge increment_seg` counter in the top level with configurable windows and fully synchronous logic.
- Adds a posted-write FIFO with a valid/ready handshake toward the display, plus a status register.

Parameters:
- ADDR_W, 32, CPU address width.
- DATA_W, 32, data width.
- RAM_AW, 12, RAM address width. The RAM window is 0 .. 2^RAM_AW-1, minus the MMIO windows.
- RNG_ADDR, 99, read-only RNG address.
- DOT_BASE, 100, first X-location address.
- DOT_COUNT, 450, dots per axis. X window is DOT_BASE .. DOT_BASE+DOT_COUNT-1; Y window is the next DOT_COUNT addresses.
- SEG_ADDR, 1000, generation-counter address.
- STATUS_ADDR, 1001, status/control address.
- FIFO_DEPTH, 8, dot FIFO entries (power of 2, ≥2).
- CNT_W, 14, generation-counter width.

Ports:
- clock  in  1  system clock (50 MHz domain).
- reset  in  1  asynchronous, active-low reset. The only clock is `clock`.
- cpu_addr  in  ADDR_W  processor data address.
- cpu_wdata  in  DATA_W  processor store data.
- cpu_wren  in  1  processor store strobe.
- cpu_rdata  out  DATA_W  load data, valid one cycle after the address.
- ram_addr  out  RAM_AW  RAM address, equal to cpu_addr[RAM_AW-1:0].
- ram_wren  out  1  RAM write enable.
- ram_wdata  out  DATA_W  RAM write data, equal to cpu_wdata.
- ram_rdata  in  DATA_W  RAM synchronous read data (1-cycle latency).
- rng_data  in  DATA_W  current LFSR value.
- dot_valid  out  1  FIFO head valid.
- dot_ready  in  1  display accepts the head entry.
- dot_is_y  out  1  head entry targets the Y array.
- dot_id  out  $clog2(DOT_COUNT)  head entry dot index.
- dot_loc  out  DATA_W  head entry location value.
- seg_value  out  CNT_W  generation count for seg7_handle.
- dot_overflow  out  1  sticky flag: a dot write was dropped.

Behaviour:
- Reset (reset=0, asynchronous):
  - FIFO is emptied; dot_valid=0, dot_is_y=0, dot_id=0, dot_loc=0.
  - seg_value=0, dot_overflow=0, cpu_rdata=0.
  - Applies mid-transfer: queued entries are discarded and nothing is popped.
  - Release is synchronous to clock.
- Decode is combinational on cpu_addr, evaluated in this priority order:
  1. RNG_ADDR
  2. SEG_ADDR
  3. STATUS_ADDR
  4. X window
  5. Y window
  6. RAM (cpu_addr < 2^RAM_AW)
  7. unmapped
- ram_wren = cpu_wren AND the RAM region is selected. A store to an MMIO address never writes RAM.
- Read path:
  - The region select and rng_data/status are registered at cycle N; cpu_rdata is muxed at N+1.
  - RAM region returns ram_rdata; RNG returns the rng_data sampled at N.
  - STATUS returns {zero-pad, fifo_count[$clog2(FIFO_DEPTH):0], dot_overflow} sampled at N, with dot_overflow in bit 0.
  - SEG returns the zero-extended seg_value.
  - Unmapped returns 0.
- Dot FIFO:
  - A store in the X/Y window pushes {is_y, id = addr - window base, cpu_wdata}.
  - Head is presented when dot_valid=1; the entry pops on the rising edge with dot_valid & dot_ready.
  - Push and pop in the same cycle are both performed, including when full: count unchanged, no overflow.
  - Push when full with no pop: the entry is dropped and dot_overflow is set.
  - Pop when empty is ignored.
  - Entries are delivered in order.
- Status: a store to STATUS_ADDR with wdata[0]=1 clears dot_overflow. If the same edge also drops a dot write, set wins.
- Generation counter: each store cycle to SEG_ADDR increments seg_value by 1, wrapping 2^CNT_W-1 → 0. Back-to-back stores increment once per cycle.

Optional Feature:
- Macro: MMIO_SEG_LOAD_EN.
- Defined: a store to SEG_ADDR with wdata[31]=1 loads seg_value ← wdata[CNT_W-1:0]; with wdata[31]=0 it increments.
- Undefined: every store increments, and wdata is ignored.

Test Plan:
- Reset/RAM: reset low → all outputs 0. Release, store 0x1234 to addr 5 → ram_wren=1. Load addr 5 → cpu_rdata=0x1234 one cycle later. Store to 100 → ram_wren=0.
- RNG: rng_data=0xDEADBEEF while loading addr 99 → cpu_rdata=0xDEADBEEF at N+1, even if rng_data changes at N+1.
- Dot FIFO: dot_ready=0, store 7 to addr 103 then 9 to addr 551 → dot_valid=1, head {is_y=0, id=3, loc=7}. Raise dot_ready → second head {is_y=1, id=1, loc=9}, then dot_valid=0.
- Overflow: dot_ready=0, 9 stores with FIFO_DEPTH=8 → dot_overflow=1, status reads 0x11. Store 1 to 1001 → dot_overflow=0. 8 stores when full with dot_ready=1 each cycle → no overflow.
- Counter: 3 stores to 1000 → seg_value=3. Force 16383+1 increments → wraps to 0. With MMIO_SEG_LOAD_EN, store 0x80000064 → seg_value=100.
- Async reset: assert reset mid-burst with FIFO holding 5 entries → immediately dot_valid=0, seg_value=0, no pop occurs.
